exe_mem_skid_reg: RTL and testbench
===================================

// Module: exe_mem_skid_reg
// PURPOSE
//  Parametrised EXE->MEM pipeline register with valid/ready handshake and 2-entry skid buffer.
//  Sits between the EXE stage (ALU result, store data, control) and the MEM stage.
//  Adds backpressure, bubble tracking and flush over the plain EXE stage register.
//  in_ready is a function of state only, so there is no combinational ready path from MEM back to EXE.
// PARAMETERS
//  DATA_W  32  width of alu_result, val_rm, pc, instr
//  DEST_W  4   destination register index width
// PORTS
//  clk             in   1       sole clock, rising edge
//  rst             in   1       synchronous, active-low reset
//  flush           in   1       kill all held entries (branch taken / exception)
//  in_valid        in   1       EXE presents a valid entry
//  in_ready        out  1       block can accept this cycle
//  in_wb_en        in   1       register writeback enable
//  in_mem_r_en     in   1       load enable
//  in_mem_w_en     in   1       store enable
//  in_alu_result   in   DATA_W  ALU result / memory address
//  in_val_rm       in   DATA_W  store data
//  in_pc           in   DATA_W  PC of the instruction
//  in_instr        in   DATA_W  instruction word
//  in_dest         in   DEST_W  destination register
//  out_valid       out  1       MEM-side entry valid
//  out_ready       in   1       MEM consumes this cycle
//  out_*           out  —       same fields and widths as in_* (wb_en .. dest)
// BEHAVIOUR
//  - Storage: main slot M (drives out_*) and skid slot S. States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1).
//  - in_ready = !S.valid. out_valid = M.valid. Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - EMPTY: accept -> ONE (M <= in).
//  - ONE: accept & pop -> ONE (M <= in). Accept & !pop -> FULL (S <= in). Pop & !accept -> EMPTY.
//  - FULL: pop -> ONE (M <= S, S cleared). No pop -> hold. in_ready=0, so no accept.
//  - Latency: 1 cycle, in accept edge to out_valid. Throughput: 1 entry/cycle while out_ready=1.
//  - out_* are stable while out_valid=1 and out_ready=0.
//  - When M is invalid: out_wb_en, out_mem_r_en and out_mem_w_en are forced 0. Datapath fields hold their last value.
//  - flush: next state EMPTY. Both valids and all enable bits cleared. Any accept in the flush cycle is discarded.
//    A pop in the flush cycle still counts for the entry MEM consumed. in_ready=1 on the following cycle.
//  - Reset: rst=0 at a clk edge -> EMPTY. All out_* = 0, out_valid=0. in_ready=1 from the first cycle after reset.
//    Reset overrides flush and handshake. Reset mid-stream drops all held entries.
//  - No width arithmetic: fields are stored verbatim.
// CONFIGURATION
//  - Macro EXE_MEM_FWD_EN defined: adds outputs fwd_valid (1), fwd_dest (DEST_W) and fwd_data (DATA_W).
//    fwd_valid = M.valid & M.wb_en & !M.mem_r_en; fwd_dest/fwd_data = M.dest / M.alu_result.
//    These feed the forwarding unit. They are purely combinational from M.
//  - Macro undefined: the ports are absent. No forwarding logic is present.
// STRUCTURE
//  - Package exe_mem_pkg: struct exe_mem_t {wb_en, mem_r_en, mem_w_en, alu_result, val_rm, pc, instr, dest}.
//    Also state enum {ST_EMPTY, ST_ONE, ST_FULL} and the DATA_W/DEST_W defaults.
//  - One sub-module, pipe_skid_slot: a payload register with valid, load, clear and sync active-low reset.
//    Instantiated twice (M, S). Top holds the state FSM and mux.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, all out_*=0; in_ready=1 after release.
//  2. Streaming: out_ready=1, 4 back-to-back entries (pc=0x0,0x4,0x8,0xC) -> each on out_pc 1 cycle later; no loss, in_ready stays 1.
//  3. Backpressure: out_ready=0, push pc=0x10 then 0x14 -> FULL, in_ready=0; raise out_ready -> 0x10 then 0x14 out in order.
//  4. Flush in FULL with in_valid=1 (pc=0x18) -> next cycle out_valid=0, out_wb_en=0, in_ready=1; 0x18 never appears.
//  5. Simultaneous accept+pop in ONE: M=0x20 popped, 0x24 accepted -> out_pc=0x24 next cycle, state stays ONE.
//  6. With EXE_MEM_FWD_EN: M={wb_en=1, mem_r_en=0, dest=5, alu_result=0xDEAD} -> fwd_valid=1, fwd_dest=5,
//     fwd_data=0xDEAD. With mem_r_en=1 -> fwd_valid=0.

Source files
------------

// File: rtl/exe_mem_pkg.sv
// Shared types for the EXE->MEM skid register: the stage payload struct,
// the occupancy state encoding and the default field widths.
package exe_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEST_W = 4;

  // Number of enable bits at the top of a packed payload (wb_en, mem_r_en, mem_w_en)
  localparam int CTRL_W = 3;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] val_rm;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_DEST_W-1:0] dest;
  } exe_mem_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with a valid flag. Clear drops the entry and zeroes the
// top CLR_W bits (the enables) while the datapath bits keep their last value.
module pipe_skid_slot #(
  parameter int W     = 8,
  parameter int CLR_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid               <= 1'b0;
      r_data[W-1 -: CLR_W]  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional macro EXE_MEM_FWD_EN adds the fwd_valid/fwd_dest/fwd_data outputs.
module exe_mem_skid_reg
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEST_W = DEF_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [DEST_W-1:0] out_dest
`ifdef EXE_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int PAY_W = CTRL_W + 4 * DATA_W + DEST_W;

  state_e             r_state;
  logic               w_accept;
  logic               w_pop;
  logic [PAY_W-1:0]   w_in_pay;
  logic               w_m_load;
  logic               w_m_clear;
  logic [PAY_W-1:0]   w_m_next;
  logic               w_m_valid;
  logic [PAY_W-1:0]   w_m_data;
  logic               w_s_load;
  logic               w_s_clear;
  logic               w_s_valid;
  logic [PAY_W-1:0]   w_s_data;
  logic               w_m_wb_en;
  logic               w_m_mem_r_en;
  logic               w_m_mem_w_en;

  assign w_in_pay = {in_wb_en, in_mem_r_en, in_mem_w_en,
                     in_alu_result, in_val_rm, in_pc, in_instr, in_dest};

  // Ready depends only on the skid slot, so MEM's ready never reaches EXE combinationally
  assign in_ready  = !w_s_valid;
  assign out_valid = w_m_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_m_load  = 1'b0;
    w_m_clear = 1'b0;
    w_m_next  = w_in_pay;
    w_s_load  = 1'b0;
    w_s_clear = 1'b0;
    if (flush) begin
      w_m_clear = 1'b1;
      w_s_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: w_m_load = w_accept;
        ST_ONE: begin
          w_m_load  = w_accept & w_pop;
          w_s_load  = w_accept & !w_pop;
          w_m_clear = w_pop & !w_accept;
        end
        ST_FULL: begin
          w_m_load  = w_pop;
          w_m_next  = w_s_data;
          w_s_clear = w_pop;
        end
        default: begin
          w_m_clear = 1'b1;
          w_s_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_pop)      r_state <= ST_FULL;
          else if (w_pop && !w_accept) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_pop) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  pipe_skid_slot #(.W(PAY_W), .CLR_W(CTRL_W)) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_data  (w_m_next),
    .o_valid (w_m_valid),
    .o_data  (w_m_data)
  );

  pipe_skid_slot #(.W(PAY_W), .CLR_W(CTRL_W)) u_slot_s (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_s_load),
    .i_clear (w_s_clear),
    .i_data  (w_in_pay),
    .o_valid (w_s_valid),
    .o_data  (w_s_data)
  );

  assign {w_m_wb_en, w_m_mem_r_en, w_m_mem_w_en,
          out_alu_result, out_val_rm, out_pc, out_instr, out_dest} = w_m_data;

  assign out_wb_en    = w_m_valid & w_m_wb_en;
  assign out_mem_r_en = w_m_valid & w_m_mem_r_en;
  assign out_mem_w_en = w_m_valid & w_m_mem_w_en;

`ifdef EXE_MEM_FWD_EN
  // Loads are excluded: their result is not known until MEM completes
  assign fwd_valid = w_m_valid & w_m_wb_en & !w_m_mem_r_en;
  assign fwd_dest  = out_dest;
  assign fwd_data  = out_alu_result;
`endif

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Randomized bench for exe_mem_skid_reg: a 2-deep queue model predicts every output.
// Build with EXE_MEM_FWD_EN defined to also check the forwarding outputs.
module tb_exe_mem_skid_reg;
  import exe_mem_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int RW = DEF_DEST_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_wb_en, in_mem_r_en, in_mem_w_en;
  logic [DW-1:0] in_alu_result, in_val_rm, in_pc, in_instr;
  logic [RW-1:0] in_dest;
  logic          out_valid;
  logic          out_ready;
  logic          out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [DW-1:0] out_alu_result, out_val_rm, out_pc, out_instr;
  logic [RW-1:0] out_dest;
`ifdef EXE_MEM_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_dest;
  logic [DW-1:0] fwd_data;
`endif

  int checkCount = 0;
  int failCount  = 0;

  exe_mem_t modelQ[$];
  exe_mem_t shown;

  always #5 clk = ~clk;

  exe_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb_en       (in_wb_en),
    .in_mem_r_en    (in_mem_r_en),
    .in_mem_w_en    (in_mem_w_en),
    .in_alu_result  (in_alu_result),
    .in_val_rm      (in_val_rm),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_dest        (in_dest),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb_en      (out_wb_en),
    .out_mem_r_en   (out_mem_r_en),
    .out_mem_w_en   (out_mem_w_en),
    .out_alu_result (out_alu_result),
    .out_val_rm     (out_val_rm),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_dest       (out_dest)
`ifdef EXE_MEM_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_data       (fwd_data)
`endif
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic exe_mem_t makeEntry(input logic [DW-1:0] pc);
    exe_mem_t e;
    e.wb_en      = 1'($urandom);
    e.mem_r_en   = 1'($urandom);
    e.mem_w_en   = 1'($urandom);
    e.alu_result = $urandom;
    e.val_rm     = $urandom;
    e.pc         = pc;
    e.instr      = $urandom;
    e.dest       = RW'($urandom);
    return e;
  endfunction

  // Compare every DUT output with the queue model after an edge has settled
  task automatic checkAll();
    exe_mem_t observed;
    exe_mem_t expected;
    observed = '{out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_result,
                 out_val_rm, out_pc, out_instr, out_dest};
    expected = shown;
    if (modelQ.size() == 0) begin
      expected.wb_en    = 1'b0;
      expected.mem_r_en = 1'b0;
      expected.mem_w_en = 1'b0;
    end
    checkOutput("out_valid", 256'(out_valid), 256'(modelQ.size() > 0));
    checkOutput("in_ready",  256'(in_ready),  256'(modelQ.size() < 2));
    checkOutput("out_fields", 256'(observed), 256'(expected));
`ifdef EXE_MEM_FWD_EN
    checkOutput("fwd_valid", 256'(fwd_valid),
                256'(modelQ.size() > 0 && shown.wb_en && !shown.mem_r_en));
    checkOutput("fwd_dest", 256'(fwd_dest), 256'(shown.dest));
    checkOutput("fwd_data", 256'(fwd_data), 256'(shown.alu_result));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic applyStimulus(input logic r, input logic fl, input logic v,
                               input exe_mem_t e, input logic ordy);
    bit doPop;
    bit doPush;
    rst           = r;
    flush         = fl;
    in_valid      = v;
    in_wb_en      = e.wb_en;
    in_mem_r_en   = e.mem_r_en;
    in_mem_w_en   = e.mem_w_en;
    in_alu_result = e.alu_result;
    in_val_rm     = e.val_rm;
    in_pc         = e.pc;
    in_instr      = e.instr;
    in_dest       = e.dest;
    out_ready     = ordy;
    doPop  = (modelQ.size() > 0) && ordy;
    doPush = v && (modelQ.size() < 2);
    @(posedge clk);
    #1;
    if (!r) begin
      modelQ.delete();
      shown = '0;
    end else if (fl) begin
      modelQ.delete();
    end else begin
      if (doPop)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(e);
      if (modelQ.size() > 0) shown = modelQ[0];
    end
    checkAll();
  endtask

  initial begin
    exe_mem_t e;
    exe_mem_t idle;
    idle = '0;
    shown = '0;

    // Reset held two cycles while EXE keeps presenting an entry
    applyStimulus(1'b0, 1'b0, 1'b1, makeEntry(32'h100), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, makeEntry(32'h104), 1'b0);
    checkOutput("reset_pc", 256'(out_pc), 256'(0));

    // Back-to-back streaming
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'(i * 4)), 1'b1);
    checkOutput("stream_last_pc", 256'(out_pc), 256'(32'hC));
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Backpressure fills both slots, then drains in order
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h10), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h14), 1'b0);
    checkOutput("full_ready", 256'(in_ready), 256'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);
    checkOutput("drain_pc", 256'(out_pc), 256'(32'h14));
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Flush while full with a new entry offered
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h10), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h14), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, makeEntry(32'h18), 1'b0);
    checkOutput("flush_wb_en", 256'(out_wb_en), 256'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Accept and pop in the same cycle while holding one entry
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h20), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, makeEntry(32'h24), 1'b1);
    checkOutput("swap_pc", 256'(out_pc), 256'(32'h24));
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Forwarding candidates: ALU writeback, then a load to the same register
    e = makeEntry(32'h28);
    e.wb_en = 1'b1; e.mem_r_en = 1'b0; e.dest = RW'(5); e.alu_result = 32'hDEAD;
    applyStimulus(1'b1, 1'b0, 1'b1, e, 1'b1);
    e.mem_r_en = 1'b1; e.pc = 32'h2C;
    applyStimulus(1'b1, 1'b0, 1'b1, e, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(99) != 0), ($urandom_range(19) == 0),
                    ($urandom_range(9) < 7), makeEntry($urandom), ($urandom_range(9) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
